// File: rtl/nn_ram_pkg.sv
// Shared definitions for the weight RAM fetch path: default widths, the layer
// index type and the fetch sequencer state encoding.
package nn_ram_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 10;
    localparam int NUM_LAYERS = 3;

    typedef logic [1:0] layer_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } fetch_state_e;

    // Layer indices at or above NUM_LAYERS have no weights in RAM.
    function automatic logic layer_is_valid(input layer_t layer);
        return int'(layer) < NUM_LAYERS;
    endfunction

endpackage

// File: rtl/weight_fetch_responder_if.sv
// Bus bundle between the weight fetch responder, the network controller, the
// weight RAM read port and the neuron array weight input.
interface weight_fetch_responder_if #(
    parameter int DATA_W = nn_ram_pkg::DATA_W,
    parameter int ADDR_W = nn_ram_pkg::ADDR_W,
    parameter int IDX_W  = 4
);
    import nn_ram_pkg::*;

    logic              start;
    layer_t            layer;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              wt_valid;
    logic [DATA_W-1:0] wt_data;
    logic [IDX_W-1:0]  wt_index;
    logic              done;
    logic              busy;
    logic              err;

    // Responder side.
    modport slave (
        input  start, layer, ram_rdata,
        output ram_en, ram_addr, wt_valid, wt_data, wt_index, done, busy, err
    );

    // Controller / RAM / neuron array side.
    modport master (
        output start, layer, ram_rdata,
        input  ram_en, ram_addr, wt_valid, wt_data, wt_index, done, busy, err
    );

endinterface

// File: rtl/weight_fetch_responder_ram_read_align.sv
// ram_read_align: lines the RAM read response up with its request. The read
// enable and word position are delayed one cycle to match the RAM latency;
// the read data passes straight through while valid and is held otherwise.
module ram_read_align #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  index_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] hold_q;

    // Delay the request one cycle and keep the last delivered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            index_q <= '0;
            hold_q  <= '0;
        end else begin
            valid_q <= en_i;
            if (en_i) begin
                index_q <= idx_i;
            end
            if (valid_q) begin
                hold_q <= rdata_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign index_o = index_q;
    assign data_o  = valid_q ? rdata_i : hold_q;

endmodule

// File: rtl/weight_fetch_responder.sv
// weight_fetch_responder: on a start from the network controller, reads the
// WORDS_PER_LAYER weight words of the requested layer from RAM and streams
// them to the neuron array, then pulses done. An invalid layer finishes with
// err and no RAM traffic.
// Optional feature: define WEIGHT_FETCH_CHECKSUM_EN to add a checksum output
// carrying the modulo-2^DATA_W sum of the words of the last fetch.
module weight_fetch_responder #(
    parameter int DATA_W          = nn_ram_pkg::DATA_W,
    parameter int ADDR_W          = nn_ram_pkg::ADDR_W,
    parameter int WORDS_PER_LAYER = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    weight_fetch_responder_if.slave bus
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]       checksum
`endif
);
    import nn_ram_pkg::*;

    localparam int IDX_W = (WORDS_PER_LAYER > 1) ? $clog2(WORDS_PER_LAYER) : 1;
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(WORDS_PER_LAYER - 1);

    fetch_state_e      state_q, state_d;
    logic              ram_en_q, ram_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic              inval_q, inval_d;
    logic              wait_q, wait_d;

    logic              start_acc;
    logic [ADDR_W-1:0] base;
    logic              wt_valid;
    logic [IDX_W-1:0]  wt_index;
    logic [DATA_W-1:0] wt_data;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    // Layer base address; wraps naturally in ADDR_W bits.
    assign base      = ADDR_W'(int'(bus.layer) * WORDS_PER_LAYER);

    // Register the sequencer state and the RAM request outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the address and index registers are reset too, because the RAM
    // and weight outputs must read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            k_q        <= '0;
            inval_q    <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_en_q   <= ram_en_d;
            ram_addr_q <= ram_addr_d;
            k_q        <= k_d;
            inval_q    <= inval_d;
            wait_q     <= wait_d;
        end
    end

    // Next-state and next request: issue one read per READ cycle, then drain.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ram_en_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        k_d        = k_q;
        inval_d    = inval_q;
        wait_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (layer_is_valid(bus.layer)) begin
                        state_d    = ST_READ;
                        ram_en_d   = 1'b1;
                        ram_addr_d = base;
                        k_d        = '0;
                        inval_d    = 1'b0;
                    end else begin
                        // Invalid layer: spend one busy cycle in FINISH so
                        // done/err never land directly after start.
                        state_d = ST_FINISH;
                        inval_d = 1'b1;
                        wait_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    k_d        = k_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                if (!wait_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    ram_read_align #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_align (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ram_en_q),
        .idx_i   (k_q),
        .rdata_i (bus.ram_rdata),
        .valid_o (wt_valid),
        .index_o (wt_index),
        .data_o  (wt_data)
    );

    assign bus.ram_en   = ram_en_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.wt_valid = wt_valid;
    assign bus.wt_index = wt_index;
    assign bus.wt_data  = wt_data;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_FINISH) && !wait_q;
    assign bus.err      = (state_q == ST_FINISH) && !wait_q && inval_q;

`ifdef WEIGHT_FETCH_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Sum delivered words; cleared on every accepted start, held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (wt_valid) begin
            csum_q <= csum_q + wt_data;
        end
    end

    assign checksum = csum_q;
`else
    // start_acc only feeds the checksum accumulator.
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_weight_fetch_responder.sv
// Self-checking bench for weight_fetch_responder: table of fetches against a
// scoreboard of expected RAM addresses and weight words, plus hand-written
// sequences for ignored start, back-to-back start, reset and address wrap.
`timescale 1ns/1ps
module tb_weight_fetch_responder;

    localparam int W        = 16;
    localparam int IW       = $clog2(W);
    localparam int EXP_DONE = W + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    weight_fetch_responder_if #(.DATA_W(16), .ADDR_W(10), .IDX_W(IW)) ifa ();
    weight_fetch_responder_if #(.DATA_W(16), .ADDR_W(5),  .IDX_W(IW)) ifb ();

`ifdef WEIGHT_FETCH_CHECKSUM_EN
    logic [15:0] csum_a, csum_b;
`endif

    weight_fetch_responder #(.DATA_W(16), .ADDR_W(10), .WORDS_PER_LAYER(W)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
`ifdef WEIGHT_FETCH_CHECKSUM_EN
        , .checksum (csum_a)
`endif
    );

    weight_fetch_responder #(.DATA_W(16), .ADDR_W(5), .WORDS_PER_LAYER(W)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
`ifdef WEIGHT_FETCH_CHECKSUM_EN
        , .checksum (csum_b)
`endif
    );

    // RAM models: one-cycle read latency.
    logic [15:0] mem_a [1024];
    logic [15:0] mem_b [32];
    logic [15:0] rdata_a = '0;
    logic [15:0] rdata_b = '0;
    always @(posedge clk) begin
        if (ifa.ram_en) rdata_a <= mem_a[ifa.ram_addr];
        if (ifb.ram_en) rdata_b <= mem_b[ifb.ram_addr];
    end
    assign ifa.ram_rdata = rdata_a;
    assign ifb.ram_rdata = rdata_b;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } wt_exp_t;

    typedef struct {
        logic [1:0] layer;
        logic       exp_err;
        int         exp_done;
        int         exp_en;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    logic sel    = 1'b0;

    int unsigned exp_addr[$];
    wt_exp_t     exp_wt[$];
    logic [31:0] exp_hold_addr = '0;
    logic [15:0] exp_hold_data = '0;
    logic [15:0] exp_csum      = '0;

    logic        s_en, s_vld, s_done, s_err, s_busy;
    logic [31:0] s_addr, s_idx, s_data;
    int          done_cnt, en_cnt, first_en, first_vld, last_vld, last_done;
    logic        last_err;
    logic [31:0] last_csum = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Sample the selected DUT and compare RAM requests and weight words
    // against the scoreboard.
    task automatic monitor();
        if (sel) begin
            s_en = ifb.ram_en;  s_addr = 32'(ifb.ram_addr);
            s_vld = ifb.wt_valid; s_idx = 32'(ifb.wt_index); s_data = 32'(ifb.wt_data);
            s_done = ifb.done; s_err = ifb.err; s_busy = ifb.busy;
        end else begin
            s_en = ifa.ram_en;  s_addr = 32'(ifa.ram_addr);
            s_vld = ifa.wt_valid; s_idx = 32'(ifa.wt_index); s_data = 32'(ifa.wt_data);
            s_done = ifa.done; s_err = ifa.err; s_busy = ifa.busy;
        end
        if (s_en === 1'b1) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc_n;
            if (exp_addr.size() == 0) check("ram_en_spurious", 32'(s_en), 32'd0);
            else check("ram_addr", s_addr, exp_addr.pop_front());
        end
        if (s_vld === 1'b1) begin
            wt_exp_t e;
            if (first_vld < 0) first_vld = cyc_n;
            last_vld = cyc_n;
            if (exp_wt.size() == 0) check("wt_valid_spurious", 32'(s_vld), 32'd0);
            else begin
                e = exp_wt.pop_front();
                check("wt_index", s_idx, 32'(e.idx));
                check("wt_data", s_data, 32'(e.data));
            end
        end
        if (s_done === 1'b1) begin
            done_cnt++;
            last_done = cyc_n;
            last_err  = s_err;
`ifdef WEIGHT_FETCH_CHECKSUM_EN
            last_csum = sel ? 32'(csum_b) : 32'(csum_a);
`endif
        end
        if (s_err === 1'b1 && s_done !== 1'b1) check("err_without_done", 32'(s_err), 32'd0);
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic set_inputs(input logic s, input logic [1:0] l);
        if (sel) begin ifb.start = s; ifb.layer = l; end
        else     begin ifa.start = s; ifa.layer = l; end
    endtask

    task automatic push_expect(input logic [1:0] layer);
        int unsigned a;
        wt_exp_t e;
        int aw;
        aw = sel ? 5 : 10;
        exp_csum = '0;
        for (int k = 0; k < W; k++) begin
            a = (int'(layer) * W + k) % (1 << aw);
            e.idx  = k;
            e.data = sel ? mem_b[a] : mem_a[a];
            exp_addr.push_back(a);
            exp_wt.push_back(e);
            exp_hold_addr = a;
            exp_hold_data = e.data;
            exp_csum      = exp_csum + e.data;
        end
    endtask

    task automatic clear_stats();
        done_cnt = 0; en_cnt = 0; first_en = -1; first_vld = -1;
        last_vld = -1; last_done = -1; last_err = 1'b0;
    endtask

    // One fetch from start (cycle 0) through its done cycle; optionally a
    // second start is raised at cycle extra_at while the fetch is busy.
    task automatic run_fetch(input logic [1:0] layer, input logic exp_err,
                             input int exp_done, input int exp_en, input int extra_at);
        int t0;
        clear_stats();
        if (!exp_err) push_expect(layer);
        else exp_csum = '0;
        t0 = cyc_n;
        set_inputs(1'b1, layer);
        cyc();
        check("busy_at_start", 32'(s_busy), 32'd0);
        set_inputs(1'b0, layer);
        for (int c = 1; c <= exp_done; c++) begin
            if (c == extra_at) set_inputs(1'b1, 2'd1);
            cyc();
            if (c == extra_at) set_inputs(1'b0, layer);
            check("busy", 32'(s_busy), 32'd1);
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(last_done - t0), 32'(exp_done));
        check("err_at_done", 32'(last_err), 32'(exp_err));
        check("ram_en_count", 32'(en_cnt), 32'(exp_en));
        if (exp_en > 0) begin
            check("first_ram_en_cycle", 32'(first_en - t0), 32'd1);
            check("first_wt_valid_cycle", 32'(first_vld - t0), 32'd2);
            check("last_wt_valid_cycle", 32'(last_vld - t0), 32'(exp_en + 1));
        end
        check("addr_queue_left", 32'(exp_addr.size()), 32'd0);
        check("wt_queue_left", 32'(exp_wt.size()), 32'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
        check("checksum_at_done", last_csum, 32'(exp_csum));
`endif
    endtask

    // One idle cycle after a fetch: not busy, outputs held.
    task automatic check_idle();
        cyc();
        check("idle_busy", 32'(s_busy), 32'd0);
        check("idle_done", 32'(s_done), 32'd0);
        check("idle_ram_en", 32'(s_en), 32'd0);
        check("idle_wt_valid", 32'(s_vld), 32'd0);
        check("hold_ram_addr", s_addr, exp_hold_addr);
        check("hold_wt_data", s_data, 32'(exp_hold_data));
    endtask

    task automatic flush_expect();
        exp_addr.delete();
        exp_wt.delete();
        exp_hold_addr = '0;
        exp_hold_data = '0;
        exp_csum      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[4];

    initial begin
        vecs[0] = '{layer: 2'd1, exp_err: 1'b0, exp_done: EXP_DONE, exp_en: W};
        vecs[1] = '{layer: 2'd0, exp_err: 1'b0, exp_done: EXP_DONE, exp_en: W};
        vecs[2] = '{layer: 2'd2, exp_err: 1'b0, exp_done: EXP_DONE, exp_en: W};
        vecs[3] = '{layer: 2'd3, exp_err: 1'b1, exp_done: 2,        exp_en: 0};

        for (int i = 0; i < 1024; i++) mem_a[i] = 16'((i * 40503) ^ 16'h5A3C);
        for (int i = 0; i < 32; i++)   mem_b[i] = 16'(i * 7 + 16'h1234);

        ifa.start = 1'b0; ifa.layer = 2'd0;
        ifb.start = 1'b0; ifb.layer = 2'd0;
        clear_stats();

        // Reset state.
        reset = 1'b1;
        @(posedge clk); #1;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_ram_en",   32'(ifa.ram_en),   32'd0);
        check("rst_ram_addr", 32'(ifa.ram_addr), 32'd0);
        check("rst_wt_valid", 32'(ifa.wt_valid), 32'd0);
        check("rst_wt_data",  32'(ifa.wt_data),  32'd0);
        check("rst_wt_index", 32'(ifa.wt_index), 32'd0);
        check("rst_done",     32'(ifa.done),     32'd0);
        check("rst_busy",     32'(ifa.busy),     32'd0);
        check("rst_err",      32'(ifa.err),      32'd0);
        check("rst_b_busy",   32'(ifb.busy),     32'd0);
        check("rst_b_addr",   32'(ifb.ram_addr), 32'd0);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
        check("rst_checksum", 32'(csum_a), 32'd0);
`endif
        cyc();

        // Table of fetches, each followed by an idle/hold check.
        for (int i = 0; i < 4; i++) begin
            run_fetch(vecs[i].layer, vecs[i].exp_err, vecs[i].exp_done, vecs[i].exp_en, -1);
            check_idle();
        end

        // Start during a fetch is ignored; start right after done is taken.
        run_fetch(2'd0, 1'b0, EXP_DONE, W, 5);
        run_fetch(2'd2, 1'b0, EXP_DONE, W, -1);
        check_idle();

        // Reset wins over a simultaneous start.
        clear_stats();
        set_inputs(1'b1, 2'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_inputs(1'b0, 2'd1);
        flush_expect();
        cyc();
        check("rst_prio_busy", 32'(s_busy), 32'd0);
        check("rst_prio_ram_en", 32'(s_en), 32'd0);
        repeat (3) cyc();
        check("rst_prio_no_fetch", 32'(en_cnt), 32'd0);

        // Reset at cycle 8 of a fetch aborts it.
        clear_stats();
        push_expect(2'd0);
        set_inputs(1'b1, 2'd0);
        cyc();
        set_inputs(1'b0, 2'd0);
        repeat (7) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        flush_expect();
        clear_stats();
        cyc();
        check("abort_ram_en",   32'(s_en),   32'd0);
        check("abort_ram_addr", s_addr,      32'd0);
        check("abort_wt_valid", 32'(s_vld),  32'd0);
        check("abort_wt_data",  s_data,      32'd0);
        check("abort_wt_index", s_idx,       32'd0);
        check("abort_done",     32'(s_done), 32'd0);
        check("abort_busy",     32'(s_busy), 32'd0);
        check("abort_err",      32'(s_err),  32'd0);
        repeat (W + 4) cyc();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_no_ram_en", 32'(en_cnt), 32'd0);

`ifdef WEIGHT_FETCH_CHECKSUM_EN
        // Checksum wraps modulo 2^16, and counts 1..16.
        for (int i = 0; i < W; i++) mem_a[i] = 16'hF000;
        run_fetch(2'd0, 1'b0, EXP_DONE, W, -1);
        check("checksum_f000", last_csum, 32'h0000);
        check_idle();
        for (int i = 0; i < W; i++) mem_a[i] = 16'(i + 1);
        run_fetch(2'd0, 1'b0, EXP_DONE, W, -1);
        check("checksum_1_to_16", last_csum, 32'd136);
        check_idle();
        run_fetch(2'd3, 1'b1, 2, 0, -1);
        check("checksum_invalid", last_csum, 32'd0);
        check_idle();
`endif

        // 5-bit address: layer 2 base 32 wraps to 0.
        sel = 1'b1;
        run_fetch(2'd2, 1'b0, EXP_DONE, W, -1);
        check_idle();
        check("wrap_last_addr", s_addr, 32'h0F);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
